// File: rtl/instr_encoder.sv
// instr_encoder: accepts field-level RV32I instruction requests, range-checks them,
// packs each into a 32-bit word and writes it to instruction memory at consecutive
// word addresses starting at BASE_ADDR.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 64,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_cls,
    input  logic [2:0]    req_funct3,
    input  logic          req_funct7b5,
    input  logic [4:0]    req_rd,
    input  logic [4:0]    req_rs1,
    input  logic [4:0]    req_rs2,
    input  logic [31:0]   req_imm,
    input  logic          req_last,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    output logic [CW-1:0] count,
    output logic          done,
    output logic          err
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          last_seen_q, last_seen_d;
    // The outstanding word is the final one of the session.
    logic          last_pend_q, last_pend_d;

    logic signed [31:0] imm_s;
    logic [31:0]        enc;
    logic               rej;
    logic               fits12, fits_sh, fits_b, fits_j, is_shift;
    logic               xfer, complete;
    logic [31:0]        occupancy;

    assign imm_s    = req_imm;
    assign fits12   = (imm_s >= -2048) && (imm_s <= 2047);
    // Unsigned compare also rejects negative shift amounts.
    assign fits_sh  = (req_imm <= 32'd31);
    assign fits_b   = (imm_s >= -4096) && (imm_s <= 4094) && !req_imm[0];
    assign fits_j   = (imm_s >= -1048576) && (imm_s <= 1048574) && !req_imm[0];
    assign is_shift = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);

    // Pack the request into an instruction word and flag out-of-range fields.
    always_comb begin
        enc = '0;
        rej = 1'b0;
        unique case (req_cls)
            3'd0: begin
                enc = {req_imm[11:0], req_rs1, req_funct3, req_rd, OpLoad};
                rej = !fits12;
            end
            3'd1: begin
                enc = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OpStore};
                rej = !fits12;
            end
            3'd2: begin
                enc = {1'b0, req_funct7b5, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, OpReg};
            end
            3'd3: begin
                enc = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                       req_imm[4:1], req_imm[11], OpBranch};
                rej = !fits_b;
            end
            3'd4: begin
                if (is_shift) begin
                    enc = {1'b0, req_funct7b5, 5'b0, req_imm[4:0], req_rs1, req_funct3,
                           req_rd, OpImm};
                    rej = !fits_sh;
                end else begin
                    enc = {req_imm[11:0], req_rs1, req_funct3, req_rd, OpImm};
                    rej = !fits12;
                end
            end
            3'd5: begin
                enc = {req_imm[11:0], req_rs1, 3'b000, req_rd, OpJalr};
                rej = !fits12;
            end
            3'd6: begin
                enc = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OpJal};
                rej = !fits_j;
            end
            3'd7: begin
                rej = 1'b1;
            end
        endcase
    end

    // Words written plus the one still in the output register.
    assign occupancy = 32'(count_q) + 32'(mem_we_q);
    assign req_ready = (state_q == StRun) && (!mem_we_q || mem_ready) &&
                       (occupancy < DEPTH) && !last_seen_q;
    assign xfer      = req_valid && req_ready;
    assign complete  = mem_we_q && mem_ready;

    // Session FSM and write-pointer next-state.
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        count_d     = count_q;
        err_d       = err_q;
        last_seen_d = last_seen_q;
        last_pend_d = last_pend_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StRun;
                    count_d     = '0;
                    err_d       = 1'b0;
                    mem_addr_d  = BASE_ADDR;
                    last_seen_d = 1'b0;
                    last_pend_d = 1'b0;
                end
            end
            StRun: begin
                if (complete) begin
                    count_d    = count_q + CW'(1);
                    mem_addr_d = mem_addr_q + 32'd4;
                    mem_we_d   = 1'b0;
                    if (last_pend_q || (32'(count_q) + 32'd1 == DEPTH)) begin
                        state_d = StDone;
                    end
                end
                if (xfer) begin
                    if (req_last) begin
                        last_seen_d = 1'b1;
                    end
                    if (rej) begin
                        err_d = 1'b1;
                        // A rejected final request has nothing left to write.
                        if (req_last) begin
                            state_d = StDone;
                        end
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = enc;
                        last_pend_d = req_last;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            last_seen_q <= 1'b0;
            last_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
            err_q       <= err_d;
            last_seen_q <= last_seen_d;
            last_pend_q <= last_pend_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign done      = (state_q == StDone);
    assign err       = err_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Sequential RV32I instruction encoder and program loader, the inverse of the main control decoder. It accepts field-level instruction requests (class, registers, funct, immediate) over a valid/ready handshake. It range-checks each request, packs it into a 32-bit RV32I word and writes it into instruction memory at consecutive word addresses. It is used by bring-up and test infrastructure to build programs for the single-cycle core without an external assembler.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first written word (must be 4-aligned)
DEPTH, 64, maximum number of words written per load session

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begins a session (honoured only in IDLE or DONE)
req_valid  input  1  request present
req_ready  output  1  encoder can accept a request this cycle
req_cls  input  3  0 lw, 1 sw, 2 R-type, 3 B-type, 4 I-type ALU, 5 jalr, 6 jal, 7 illegal
req_funct3  input  3  funct3 field; forced to 3'b000 for jalr
req_funct7b5  input  1  instr[30] for R-type and for I-type shifts (funct3 001/101)
req_rd  input  5  destination register
req_rs1  input  5  source register 1
req_rs2  input  5  source register 2
req_imm  input  32  signed byte immediate/offset
req_last  input  1  marks the final request of the session
mem_we  output  1  write strobe, holds until mem_ready
mem_addr  output  32  word byte address
mem_wdata  output  32  encoded instruction
mem_ready  input  1  memory accepts the write when mem_we && mem_ready
count  output  $clog2(DEPTH+1)  words written this session
done  output  1  session complete (DONE state)
err  output  1  sticky: at least one request rejected this session

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE. req_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, done=0, err=0. Reset mid-write drops the pending write.
- States: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --(last accepted word written, or last request rejected, or count reaches DEPTH)--> DONE.
  - DONE --start--> RUN.
  - start clears count, err and the write pointer (mem_addr=BASE_ADDR). start in RUN is ignored.
- req_ready = (state==RUN) && (!mem_we || mem_ready) && (count + pending < DEPTH) && !last_seen.
  - pending = 1 while a write is outstanding.
  - last_seen is set on an accepted req_last and cleared by start.
- Transfer = req_valid && req_ready. Output register holds one word. Latency: transfer at edge N gives mem_we=1 with the word from edge N until mem_ready.
  - Same-cycle write completion and new transfer is allowed (zero-bubble streaming).
- Write complete (mem_we && mem_ready): count += 1, mem_addr += 4 for the next word, mem_we drops unless a new transfer occurs in the same cycle.
- Encoding (op in [6:0], rd [11:7], f3 [14:12], rs1 [19:15], rs2 [24:20]):
  - lw: 0000011, I-format imm[11:0] in [31:20].
  - sw: 0100011, imm[11:5] in [31:25], imm[4:0] in [11:7].
  - R: 0110011, [30]=funct7b5, other funct7 bits 0.
  - B: 1100011, imm[12|10:5] in [31:25], imm[4:1|11] in [11:7].
  - I-ALU: 0010011. For f3=001/101: [31:25]={0,funct7b5,00000}, [24:20]=imm[4:0]. Otherwise imm[11:0].
  - jalr: 1100111, I-format, f3=000.
  - jal: 1101111, imm[20|10:1|11|19:12] in [31:12].
- Rejection: the request is accepted (handshake completes), nothing is written, and err is set. Rejection causes:
  - class 7;
  - I/S immediate outside [-2048, 2047];
  - shift amount imm outside [0, 31];
  - B imm outside [-4096, 4094] or odd;
  - J imm outside [-1048576, 1048574] or odd.
- DEPTH boundary: after the DEPTH-th word completes, go to DONE with done=1 even without req_last. Further requests stall (req_ready=0).
- done=1 only in DONE; outputs hold their values in DONE.

Test Plan:
- Reset then start, send addi x1,x0,5 (cls4 f3=0 rd1 imm5) with mem_ready=1 → one cycle later mem_we=1, mem_addr=0x0, mem_wdata=0x00500093; count=1.
- Stream lw x2,8(x1); sw x2,12(x1); sub x3,x1,x2 (f7b5=1, req_last on the third) back-to-back → words 0x0080A103, 0x0020A623, 0x402081B3 at addresses 0x0, 0x4, 0x8 with no bubbles; done=1, count=3.
- beq x1,x2,-4 then jal x1,8 → 0xFE208EE3, then 0x008000EF. Then beq with imm=3 → rejected, err=1, no mem_we, count unchanged.
- Hold mem_ready=0 for 5 cycles after a transfer → mem_we/addr/wdata stable, req_ready=0. When mem_ready=1, the write completes and the next request is accepted in the same cycle.
- DEPTH=4 with 6 requests → exactly 4 writes (0x0–0xC), done=1, req_ready stays 0. start → count=0, the next write goes to 0x0.
- Drive reset_n=0 while mem_we=1 → next cycle mem_we=0, state IDLE, count=0. start is required before req_ready returns to 1.
